alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared ALU.
// slave  : arbiter side (takes requests, drives ALU operands and responses)
// master : environment side (requesters plus the ALU returning alu_result)
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OP_W = 3;

    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OP_W-1:0]  req0_op;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OP_W-1:0]  req1_op;
    logic             req1_ready;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_ctrl;
    logic [WIDTH-1:0] alu_result;

    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Ports:
//   clk   - clock, all state changes on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_arbiter_if.slave: req0/req1 valid/a/b/op/ready, alu_a/alu_b/
//           alu_ctrl/alu_result, rsp0_valid/rsp1_valid/rsp_data/rsp_zero
// Flow: IDLE (grant + accept) -> EXEC (ALU evaluates latched operands)
//       -> RESP (one-cycle strobe to the served requester) -> IDLE.
// Optional feature: define ALU_ARBITER_ZERO_FLAG_EN to register rsp_zero
// alongside rsp_data; otherwise rsp_zero is tied low.
// req0_ready/req1_ready are combinational (grant depends on current valids).
module alu_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    localparam int unsigned OP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_q;      // last-served requester ID
    logic             id_q;        // requester owning the in-flight op
    logic             grant_c;
    logic             accept_c;
    logic             ready0_c;
    logic             ready1_c;
    logic [WIDTH-1:0] sel_a_c;
    logic [WIDTH-1:0] sel_b_c;
    logic [OP_W-1:0]  sel_op_c;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OP_W-1:0]  alu_ctrl_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp0_q;
    logic             rsp1_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant and ready; rst_n gating keeps ready low during reset
    always_comb begin
        state_d  = state_q;
        ready0_c = 1'b0;
        ready1_c = 1'b0;
        accept_c = 1'b0;
        grant_c  = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
        case (state_q)
            IDLE: begin
                if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
                    ready0_c = ~grant_c;
                    ready1_c = grant_c;
                    accept_c = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a_c  = grant_c ? bus.req1_a  : bus.req0_a;
        sel_b_c  = grant_c ? bus.req1_b  : bus.req0_b;
        sel_op_c = grant_c ? bus.req1_op : bus.req0_op;
    end

    // Operand latch on accept, result capture at end of EXEC, response strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            rsp_data_q <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            if (accept_c) begin
                alu_a_q    <= sel_a_c;
                alu_b_q    <= sel_b_c;
                alu_ctrl_q <= sel_op_c;
                id_q       <= grant_c;
                last_q     <= grant_c;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= bus.alu_result;
                rsp0_q     <= ~id_q;
                rsp1_q     <= id_q;
            end
        end
    end

`ifdef ALU_ARBITER_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag captured together with rsp_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (state_q == EXEC) begin
            zero_q <= (bus.alu_result == '0);
        end
    end

    assign bus.rsp_zero = zero_q;
`else
    assign bus.rsp_zero = 1'b0;
`endif

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
endmodule
